// File: rtl/m68k_bus_arbiter_pkg.sv
// Shared definitions for the 68000 bus arbiter: state encodings, status bit, defaults.
// No logic lives here.
package m68k_bus_arbiter_pkg;

   typedef enum logic [2:0] {
      ARB_IDLE     = 3'd0,
      ARB_WAIT_END = 3'd1,
      ARB_GRANT    = 3'd2,
      ARB_OWNED    = 3'd3,
      ARB_RELEASE  = 3'd4
   } arb_state_t;

   // Position of dma_active in the Pi status register.
   localparam int STATUS_DMA_ACTIVE_BIT = 12;

   localparam int GRANT_TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/m68k_bus_arbiter_sync_chain.sv
// Multi-stage synchroniser for an active-low bus line; stages preset to 1 (inactive) on reset.
// Latency STAGES c7m edges; no flow control.
module m68k_bus_arbiter_sync_chain #(
   parameter int STAGES = 2
) (
   input  logic c7m,
   input  logic op_txnrst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sr;

   always_ff @(posedge c7m or posedge op_txnrst) begin
      if (op_txnrst) begin
         sr <= '1;
      end else begin
         sr <= {sr[STAGES-2:0], d};
      end
   end

   assign q = sr[STAGES-1];

endmodule

// File: rtl/m68k_bus_arbiter.sv
// 68000 BR/BG/BGACK arbiter between the Pi transfer engine and external DMA masters.
// BR_n fall to BG_n low in SYNC_STAGES+2 edges when the engine is idle; the engine is held at S1 while DMA pends.
module m68k_bus_arbiter
   import m68k_bus_arbiter_pkg::*;
#(
   parameter int GRANT_TIMEOUT = GRANT_TIMEOUT_DEFAULT,
   parameter int SYNC_STAGES   = 2
) (
   input  logic c7m,
   input  logic op_txnrst,
   input  logic m68k_br_n,
   input  logic m68k_bgack_n,
   input  logic m68k_as_n_in,
   input  logic eng_idle,
   output logic m68k_bg_n,
   output logic eng_start_en,
   output logic bus_drive_en,
   output logic dma_active,
   output logic grant_timeout
);

   localparam int CNT_W = $clog2(GRANT_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(GRANT_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GRANT_TIMEOUT - 1);

   logic br_s;
   logic bgack_s;
   logic as_s;

   arb_state_t       state;
   arb_state_t       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             tmo_nxt;

   m68k_bus_arbiter_sync_chain #(.STAGES(SYNC_STAGES)) u_sync_br (
      .c7m       (c7m),
      .op_txnrst (op_txnrst),
      .d         (m68k_br_n),
      .q         (br_s)
   );

   m68k_bus_arbiter_sync_chain #(.STAGES(SYNC_STAGES)) u_sync_bgack (
      .c7m       (c7m),
      .op_txnrst (op_txnrst),
      .d         (m68k_bgack_n),
      .q         (bgack_s)
   );

   m68k_bus_arbiter_sync_chain #(.STAGES(SYNC_STAGES)) u_sync_as (
      .c7m       (c7m),
      .op_txnrst (op_txnrst),
      .d         (m68k_as_n_in),
      .q         (as_s)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      tmo_nxt   = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (!br_s) state_nxt = ARB_WAIT_END;
         end
         ARB_WAIT_END: begin
            if (br_s) begin
               state_nxt = ARB_IDLE;
            end else if (eng_idle) begin
               state_nxt = ARB_GRANT;
               cnt_nxt   = '0;
            end
         end
         ARB_GRANT: begin
            if (cnt != CNT_MAX) cnt_nxt = cnt + CNT_W'(1);
            // Acknowledge only counts once the previous master has dropped AS_n.
            if (!bgack_s && as_s) begin
               state_nxt = ARB_OWNED;
            end else if (br_s && bgack_s) begin
               state_nxt = ARB_RELEASE;
            end else if (cnt == CNT_LAST) begin
               state_nxt = ARB_RELEASE;
               tmo_nxt   = 1'b1;
            end
         end
         ARB_OWNED: begin
            if (bgack_s) begin
               if (!br_s) begin
                  state_nxt = ARB_GRANT;
                  cnt_nxt   = '0;
               end else begin
                  state_nxt = ARB_RELEASE;
               end
            end
         end
         ARB_RELEASE: begin
            state_nxt = ARB_IDLE;
         end
         default: begin
            state_nxt = ARB_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they change on the same edge as the state.
   always_ff @(posedge c7m or posedge op_txnrst) begin
      if (op_txnrst) begin
         state         <= ARB_IDLE;
         cnt           <= '0;
         m68k_bg_n     <= 1'b1;
         bus_drive_en  <= 1'b1;
         dma_active    <= 1'b0;
         grant_timeout <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         m68k_bg_n     <= (state_nxt != ARB_GRANT);
         bus_drive_en  <= (state_nxt == ARB_IDLE) || (state_nxt == ARB_WAIT_END);
         dma_active    <= (state_nxt == ARB_OWNED);
         grant_timeout <= tmo_nxt;
      end
   end

   // DMA wins ties: a pending or stray external request blocks a new engine start.
   assign eng_start_en = (state == ARB_IDLE) && br_s && bgack_s;

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// Directed-vector bench for m68k_bus_arbiter with hand-computed expectations.
// Inputs change and outputs are sampled 1ns after each rising c7m edge.
module tb_m68k_bus_arbiter;

   logic c7m = 1'b0;
   logic op_txnrst;
   logic m68k_br_n;
   logic m68k_bgack_n;
   logic m68k_as_n_in;
   logic eng_idle;
   logic m68k_bg_n;
   logic eng_start_en;
   logic bus_drive_en;
   logic dma_active;
   logic grant_timeout;

   int n_checks = 0;
   int n_pass   = 0;

   m68k_bus_arbiter #(.GRANT_TIMEOUT(15), .SYNC_STAGES(2)) dut (
      .c7m           (c7m),
      .op_txnrst     (op_txnrst),
      .m68k_br_n     (m68k_br_n),
      .m68k_bgack_n  (m68k_bgack_n),
      .m68k_as_n_in  (m68k_as_n_in),
      .eng_idle      (eng_idle),
      .m68k_bg_n     (m68k_bg_n),
      .eng_start_en  (eng_start_en),
      .bus_drive_en  (bus_drive_en),
      .dma_active    (dma_active),
      .grant_timeout (grant_timeout)
   );

   always #5 c7m = ~c7m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge c7m);
         #1;
      end
   endtask

   // Checks all registered outputs plus eng_start_en at once.
   task automatic chk_all(input string tag, input logic bg, input logic se,
                          input logic de, input logic da, input logic to);
      chk({tag, ".bg_n"},  {31'd0, m68k_bg_n},     {31'd0, bg});
      chk({tag, ".start"}, {31'd0, eng_start_en},  {31'd0, se});
      chk({tag, ".drive"}, {31'd0, bus_drive_en},  {31'd0, de});
      chk({tag, ".dma"},   {31'd0, dma_active},    {31'd0, da});
      chk({tag, ".tmo"},   {31'd0, grant_timeout}, {31'd0, to});
   endtask

   initial begin
      op_txnrst    = 1'b1;
      m68k_br_n    = 1'b1;
      m68k_bgack_n = 1'b1;
      m68k_as_n_in = 1'b1;
      eng_idle     = 1'b1;
      #3;
      chk_all("reset", 1, 1, 1, 0, 0);
      step(1);
      op_txnrst = 1'b0;
      step(2);
      chk_all("idle", 1, 1, 1, 0, 0);

      // Request with engine idle: BG_n low after 4 edges.
      m68k_br_n = 1'b0;
      step(1);
      chk("t1.start_e1", {31'd0, eng_start_en}, 32'd1);
      step(1);
      chk_all("t1.e2", 1, 0, 1, 0, 0);
      step(1);
      chk_all("t1.e3", 1, 0, 1, 0, 0);
      step(1);
      chk_all("t1.e4", 0, 0, 0, 0, 0);

      // Acknowledge with AS_n high, then release with BR_n high.
      m68k_bgack_n = 1'b0;
      step(2);
      chk_all("t3.sync", 0, 0, 0, 0, 0);
      step(1);
      chk_all("t3.owned", 1, 0, 0, 1, 0);
      m68k_br_n = 1'b1;
      step(3);
      chk_all("t3.hold", 1, 0, 0, 1, 0);
      m68k_bgack_n = 1'b1;
      step(2);
      chk("t3.still_owned", {31'd0, dma_active}, 32'd1);
      step(1);
      chk_all("t3.release", 1, 0, 0, 0, 0);
      step(1);
      chk_all("t3.idle", 1, 1, 1, 0, 0);

      // Request while the engine is mid-cycle.
      eng_idle  = 1'b0;
      m68k_br_n = 1'b0;
      step(3);
      chk_all("t2.wait", 1, 0, 1, 0, 0);
      step(3);
      chk_all("t2.wait2", 1, 0, 1, 0, 0);
      eng_idle = 1'b1;
      #1;
      chk("t2.no_edge", {31'd0, m68k_bg_n}, 32'd1);
      step(1);
      chk_all("t2.grant", 0, 0, 0, 0, 0);
      m68k_br_n = 1'b1;
      step(2);
      chk("t2.grant_hold", {31'd0, m68k_bg_n}, 32'd0);
      step(1);
      chk_all("t2.withdrawn", 1, 0, 0, 0, 0);
      step(1);
      chk_all("t2.idle", 1, 1, 1, 0, 0);

      // No acknowledge: grant withdrawn after 15 clocks in GRANT, then retried.
      m68k_br_n = 1'b0;
      step(4);
      chk("t4.grant", {31'd0, m68k_bg_n}, 32'd0);
      step(14);
      chk_all("t4.last", 0, 0, 0, 0, 0);
      step(1);
      chk_all("t4.timeout", 1, 0, 0, 0, 1);
      step(1);
      chk_all("t4.idle", 1, 0, 1, 0, 0);
      step(1);
      chk_all("t4.wait", 1, 0, 1, 0, 0);
      step(1);
      chk_all("t4.regrant", 0, 0, 0, 0, 0);

      // Back-to-back masters: OWNED -> GRANT -> OWNED without driving the bus.
      m68k_bgack_n = 1'b0;
      step(3);
      chk_all("t5.owned", 1, 0, 0, 1, 0);
      m68k_bgack_n = 1'b1;
      step(2);
      chk_all("t5.owned2", 1, 0, 0, 1, 0);
      step(1);
      chk_all("t5.regrant", 0, 0, 0, 0, 0);
      m68k_bgack_n = 1'b0;
      step(2);
      chk_all("t5.grant_hold", 0, 0, 0, 0, 0);
      step(1);
      chk_all("t5.owned3", 1, 0, 0, 1, 0);

      // Asynchronous reset while OWNED.
      op_txnrst = 1'b1;
      #1;
      chk_all("t6.rst_owned", 1, 1, 1, 0, 0);
      m68k_bgack_n = 1'b1;
      m68k_br_n    = 1'b1;
      step(1);
      op_txnrst = 1'b0;
      step(2);

      // Asynchronous reset while in GRANT, then a full timeout proves the counter restarted.
      m68k_br_n = 1'b0;
      step(4);
      chk("t6.grant", {31'd0, m68k_bg_n}, 32'd0);
      step(5);
      op_txnrst = 1'b1;
      #1;
      chk_all("t6.rst_grant", 1, 1, 1, 0, 0);
      step(1);
      op_txnrst = 1'b0;
      step(4);
      chk("t6.regrant", {31'd0, m68k_bg_n}, 32'd0);
      step(14);
      chk_all("t6.last", 0, 0, 0, 0, 0);
      step(1);
      chk_all("t6.timeout", 1, 0, 0, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
